// File: rtl/led_fade_sequencer.sv
// rtl/led_fade_sequencer.sv - LED value counter and brightness ramp/breathe sequencer
// Turns debounced button pulses into a saturating counter and a stepped PWM level.
module led_fade_sequencer #(
  parameter int STEP_CYCLES = 5000000,
  parameter int MAX_LEVEL   = 4,
  parameter int LVL_W       = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              btn_pressed,
  output logic signed [3:0]       counter,
  output logic [LVL_W-1:0]        brightness,
  output logic                    ramping,
  output logic                    breathe
);

  localparam int                TW     = $clog2(STEP_CYCLES);
  localparam logic [TW-1:0]     T_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [LVL_W-1:0]  MAX_L  = LVL_W'(MAX_LEVEL);
  localparam logic [LVL_W-1:0]  ZERO_L = '0;
  localparam logic [LVL_W-1:0]  ONE_L  = LVL_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    BREATHE_UP,
    BREATHE_DOWN
  } state_t;

  state_t           state, state_nx;
  logic [TW-1:0]    timer, timer_nx;
  logic [LVL_W-1:0] tgt, tgt_nx;
  logic [LVL_W-1:0] bright_nx;

  logic cnt_up, cnt_dn, lvl_up, lvl_dn, toggle, step;

  assign cnt_up = btn_pressed[0] & ~btn_pressed[1];
  assign cnt_dn = btn_pressed[1] & ~btn_pressed[0];
  assign lvl_up = btn_pressed[2] & ~btn_pressed[3];
  assign lvl_dn = btn_pressed[3] & ~btn_pressed[2];
  assign toggle = btn_pressed[2] & btn_pressed[3];
  assign step   = (timer == T_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= 4'sd0;
    end else if (cnt_up && counter != 4'sd7) begin
      counter <= counter + 4'sd1;
    end else if (cnt_dn && counter != -4'sd8) begin
      counter <= counter - 4'sd1;
    end
  end

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    tgt_nx    = tgt;
    bright_nx = brightness;

    // Target only follows single presses while not sweeping.
    if (state == IDLE || state == RAMP) begin
      if (lvl_up && tgt != MAX_L) begin
        tgt_nx = tgt + ONE_L;
      end else if (lvl_dn && tgt != ZERO_L) begin
        tgt_nx = tgt - ONE_L;
      end
    end

    case (state)
      IDLE: begin
        timer_nx = '0;
        if (toggle) begin
          state_nx = BREATHE_UP;
        end else if (brightness != tgt) begin
          state_nx = RAMP;
        end
      end

      RAMP: begin
        if (toggle) begin
          state_nx = BREATHE_UP;
          timer_nx = '0;
        end else if (brightness == tgt) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else begin
          timer_nx = step ? '0 : timer + TW'(1);
          if (step) begin
            bright_nx = (brightness < tgt) ? brightness + ONE_L : brightness - ONE_L;
            // Compare against the updated target so a press on the step edge keeps the timer phase.
            if (bright_nx == tgt_nx) begin
              state_nx = IDLE;
            end
          end
        end
      end

      BREATHE_UP: begin
        if (toggle) begin
          state_nx = RAMP;
          timer_nx = '0;
        end else begin
          timer_nx = step ? '0 : timer + TW'(1);
          if (step) begin
            if (brightness >= MAX_L) begin
              bright_nx = MAX_L - ONE_L;
              state_nx  = BREATHE_DOWN;
            end else begin
              bright_nx = brightness + ONE_L;
              if (bright_nx == MAX_L) begin
                state_nx = BREATHE_DOWN;
              end
            end
          end
        end
      end

      BREATHE_DOWN: begin
        if (toggle) begin
          state_nx = RAMP;
          timer_nx = '0;
        end else begin
          timer_nx = step ? '0 : timer + TW'(1);
          if (step) begin
            if (brightness == ZERO_L) begin
              bright_nx = ONE_L;
              state_nx  = BREATHE_UP;
            end else begin
              bright_nx = brightness - ONE_L;
              if (bright_nx == ZERO_L) begin
                state_nx = BREATHE_UP;
              end
            end
          end
        end
      end

      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      tgt        <= '0;
      brightness <= '0;
      ramping    <= 1'b0;
      breathe    <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      tgt        <= tgt_nx;
      brightness <= bright_nx;
      ramping    <= (state_nx == RAMP);
      breathe    <= (state_nx == BREATHE_UP) || (state_nx == BREATHE_DOWN);
    end
  end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// tb/tb_led_fade_sequencer.sv - directed self-checking bench for led_fade_sequencer
module tb_led_fade_sequencer;

  logic              clk;
  logic              reset;
  logic [3:0]        btn_pressed;
  logic signed [3:0] counter;
  logic [2:0]        brightness;
  logic              ramping;
  logic              breathe;

  int n_checks = 0;
  int n_fails  = 0;

  led_fade_sequencer #(
    .STEP_CYCLES(4),
    .MAX_LEVEL  (4),
    .LVL_W      (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_pressed(btn_pressed),
    .counter    (counter),
    .brightness (brightness),
    .ramping    (ramping),
    .breathe    (breathe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int v);
    logic [3:0] e;
    e = 4'(v);
    chk(tag, {4'b0, counter}, {4'b0, e});
  endtask

  // Called at a negedge; the pulse is sampled by the following posedge.
  task automatic pulse(input logic [3:0] b);
    btn_pressed = b;
    @(negedge clk);
    btn_pressed = 4'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int exp_v;
    int seq [9];
    seq = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
    reset       = 1'b1;
    btn_pressed = 4'b0;
    wait_edges(2);
    chk_cnt("reset_counter", 0);
    chk("reset_brightness", {5'b0, brightness}, 8'd0);
    chk("reset_ramping", {7'b0, ramping}, 8'd0);
    chk("reset_breathe", {7'b0, breathe}, 8'd0);
    reset = 1'b0;
    wait_edges(1);

    // Counter saturation up then down
    for (int i = 1; i <= 9; i++) begin
      pulse(4'b0001);
      exp_v = (i > 7) ? 7 : i;
      chk_cnt($sformatf("cnt_up_%0d", i), exp_v);
    end
    for (int i = 1; i <= 16; i++) begin
      pulse(4'b0010);
      exp_v = (7 - i < -8) ? -8 : 7 - i;
      chk_cnt($sformatf("cnt_dn_%0d", i), exp_v);
    end
    pulse(4'b0011);
    chk_cnt("cnt_both_hold", -8);

    // Single ramp step
    pulse(4'b0100);
    chk("ramp1_ramping_e0", {7'b0, ramping}, 8'd0);
    wait_edges(1);
    chk("ramp1_ramping_e1", {7'b0, ramping}, 8'd1);
    wait_edges(3);
    chk("ramp1_bright_e4", {5'b0, brightness}, 8'd0);
    wait_edges(1);
    chk("ramp1_bright_e5", {5'b0, brightness}, 8'd1);
    wait_edges(1);
    chk("ramp1_ramping_e6", {7'b0, ramping}, 8'd0);

    // Return to 0 before the multi-step ramp
    pulse(4'b1000);
    wait_edges(8);
    chk("dim_back_bright", {5'b0, brightness}, 8'd0);

    // Multi-step ramp with saturating fifth press
    for (int i = 0; i < 5; i++) pulse(4'b0100);
    wait_edges(1);
    chk("multi_bright_e5", {5'b0, brightness}, 8'd1);
    wait_edges(3);
    chk("multi_bright_e8", {5'b0, brightness}, 8'd1);
    wait_edges(1);
    chk("multi_bright_e9", {5'b0, brightness}, 8'd2);
    wait_edges(4);
    chk("multi_bright_e13", {5'b0, brightness}, 8'd3);
    wait_edges(4);
    chk("multi_bright_e17", {5'b0, brightness}, 8'd4);
    wait_edges(1);
    chk("multi_ramping_e18", {7'b0, ramping}, 8'd0);
    wait_edges(8);
    chk("multi_bright_sat", {5'b0, brightness}, 8'd4);

    // Dim back to 0
    for (int i = 0; i < 4; i++) pulse(4'b1000);
    wait_edges(20);
    chk("dim_all_bright", {5'b0, brightness}, 8'd0);
    chk("dim_all_ramping", {7'b0, ramping}, 8'd0);

    // Ramp cancel
    pulse(4'b0100);
    pulse(4'b0000);
    pulse(4'b1000);
    chk("cancel_ramping_e2", {7'b0, ramping}, 8'd1);
    wait_edges(1);
    chk("cancel_ramping_e3", {7'b0, ramping}, 8'd0);
    wait_edges(17);
    chk("cancel_bright_e20", {5'b0, brightness}, 8'd0);
    chk("cancel_ramping_e20", {7'b0, ramping}, 8'd0);

    // Breathe sweep with interleaved presses
    pulse(4'b1100);
    chk("br_breathe_on", {7'b0, breathe}, 8'd1);
    chk("br_ramping_off", {7'b0, ramping}, 8'd0);
    wait_edges(3);
    chk("br_bright_e3", {5'b0, brightness}, 8'd0);
    wait_edges(1);
    chk("br_bright_0", {5'b0, brightness}, 8'(seq[0]));
    pulse(4'b0100);
    wait_edges(3);
    chk("br_bright_1", {5'b0, brightness}, 8'(seq[1]));
    pulse(4'b0001);
    chk_cnt("br_counter", -7);
    wait_edges(3);
    chk("br_bright_2", {5'b0, brightness}, 8'(seq[2]));
    for (int k = 3; k < 9; k++) begin
      wait_edges(4);
      chk($sformatf("br_bright_%0d", k), {5'b0, brightness}, 8'(seq[k]));
    end
    chk("br_breathe_still", {7'b0, breathe}, 8'd1);

    // Toggle off: ramp back to held target 0
    pulse(4'b1100);
    chk("br_off_breathe", {7'b0, breathe}, 8'd0);
    chk("br_off_ramping", {7'b0, ramping}, 8'd1);
    wait_edges(3);
    chk("br_off_bright_e3", {5'b0, brightness}, 8'd1);
    wait_edges(1);
    chk("br_off_bright_e4", {5'b0, brightness}, 8'd0);
    wait_edges(1);
    chk("br_off_ramping_end", {7'b0, ramping}, 8'd0);

    // Async reset mid-ramp at brightness 2
    for (int i = 0; i < 3; i++) pulse(4'b0100);
    wait_edges(7);
    chk("rst_pre_bright", {5'b0, brightness}, 8'd2);
    chk("rst_pre_ramping", {7'b0, ramping}, 8'd1);
    #2 reset = 1'b1;
    #1;
    chk_cnt("rst_async_counter", 0);
    chk("rst_async_bright", {5'b0, brightness}, 8'd0);
    chk("rst_async_ramping", {7'b0, ramping}, 8'd0);
    chk("rst_async_breathe", {7'b0, breathe}, 8'd0);
    wait_edges(2);
    reset = 1'b0;
    wait_edges(12);
    chk("rst_after_bright", {5'b0, brightness}, 8'd0);
    chk("rst_after_ramping", {7'b0, ramping}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
